// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a 4-entry register file: picks one of the ALU and load-unit
// writes per cycle, registers it onto the RF write port, and tracks pending writes.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int RR_ENABLE  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alu_req,
    input  logic [1:0]            alu_dest,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_gnt,
    input  logic                  mem_req,
    input  logic [1:0]            mem_dest,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_gnt,
    input  logic                  issue_valid,
    input  logic [1:0]            issue_dest,
    output logic                  issue_ready,
    input  logic [1:0]            src1,
    input  logic [1:0]            src2,
    output logic                  src1_busy,
    output logic                  src2_busy,
    output logic                  rf_write_enable,
    output logic [1:0]            rf_dest_reg,
    output logic [DATA_WIDTH-1:0] rf_write_data
);

    typedef enum logic {
        LAST_MEM = 1'b0,
        LAST_ALU = 1'b1
    } winner_e;

    winner_e               last_q, last_d;
    logic [3:0]            busy_q, busy_d;
    logic                  we_q, we_d;
    logic [1:0]            dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  alu_win, mem_win;
    logic                  any_gnt;
    logic [1:0]            gnt_dest;
    logic [DATA_WIDTH-1:0] gnt_data;

    // ALU loses a tie only under fixed priority or when it won the previous grant.
    always_comb begin
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (alu_req && mem_req) begin
            if ((RR_ENABLE != 0) && (last_q == LAST_MEM)) begin
                alu_win = 1'b1;
            end else begin
                mem_win = 1'b1;
            end
        end else begin
            alu_win = alu_req;
            mem_win = mem_req;
        end
    end

    // Grants are masked while reset is asserted so nothing is accepted then.
    always_comb begin
        alu_gnt  = reset_n && alu_win;
        mem_gnt  = reset_n && mem_win;
        any_gnt  = alu_gnt || mem_gnt;
        gnt_dest = alu_gnt ? alu_dest : mem_dest;
        gnt_data = alu_gnt ? alu_data : mem_data;
    end

    always_comb begin
        issue_ready = !busy_q[issue_dest];
        src1_busy   = busy_q[src1];
        src2_busy   = busy_q[src2];
    end

    always_comb begin
        last_d = last_q;
        we_d   = any_gnt;
        dest_d = dest_q;
        data_d = data_q;
        busy_d = busy_q;
        if (alu_gnt) begin
            last_d = LAST_ALU;
        end else if (mem_gnt) begin
            last_d = LAST_MEM;
        end
        if (any_gnt) begin
            dest_d           = gnt_dest;
            data_d           = gnt_data;
            busy_d[gnt_dest] = 1'b0;
        end
        // Set is applied after clear so a same-bit collision leaves the new issue pending.
        if (issue_valid && issue_ready) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= LAST_MEM;
            busy_q <= '0;
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            last_q <= last_d;
            busy_q <= busy_d;
            we_q   <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_dest_reg     = dest_q;
    assign rf_write_data   = data_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of write data and the register file word.
REQ-002 Parameter: RR_ENABLE, 1, selects arbitration policy: 1 = round-robin, 0 = fixed priority with mem over alu.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: alu_req, alu_dest, alu_data  in  1/2/DATA_WIDTH  ALU writeback request, target register (0-3), data.
REQ-006 Port: alu_gnt  out  1  ALU request accepted this cycle.
REQ-007 Port: mem_req, mem_dest, mem_data  in  1/2/DATA_WIDTH  load-unit writeback request, target register, data.
REQ-008 Port: mem_gnt  out  1  load request accepted this cycle.
REQ-009 Port: issue_valid, issue_dest  in  1/2  decoder announces an instruction that will later write issue_dest.
REQ-010 Port: issue_ready  out  1  issue accepted; low while issue_dest is already busy (WAW hazard).
REQ-011 Port: src1, src2  in  2/2  decoder source-register queries.
REQ-012 Port: src1_busy, src2_busy  out  1/1  queried register has a pending write.
REQ-013 Port: rf_write_enable, rf_dest_reg, rf_write_data  out  1/2/DATA_WIDTH  registered drive to the register file write port.

Function
REQ-014 Requesters SHALL hold req, dest and data stable from assertion until the cycle their gnt is high; req dropped without gnt is legal and is not recorded.
REQ-015 gnt SHALL be combinational, asserted in the same cycle as the accepted req; at most one gnt SHALL be high per cycle.
REQ-016 If only one req is high, it SHALL be granted.
REQ-017 With RR_ENABLE=1 and both reqs high, the requester not granted most recently SHALL win; the last-winner pointer updates only on a grant.
REQ-018 With RR_ENABLE=0 and both reqs high, mem SHALL win.
REQ-019 The granted dest and data SHALL appear on rf_dest_reg and rf_write_data, with rf_write_enable=1, exactly one cycle after the grant (1-cycle latency).
REQ-020 With no grant in a cycle, rf_write_enable SHALL be 0 in the next cycle; rf_dest_reg and rf_write_data hold their previous values.
REQ-021 The scoreboard SHALL be 4 busy bits; issue_valid && issue_ready sets busy[issue_dest] at the clock edge.
REQ-022 issue_ready SHALL equal !busy[issue_dest], combinational.
REQ-023 A grant to dest d SHALL clear busy[d] at the same edge at which rf_write_enable rises.
REQ-024 Set and clear of the same bit at the same edge SHALL leave the bit set (new issue wins); set and clear of different bits SHALL both take effect.
REQ-025 srcN_busy SHALL equal busy[srcN], combinational, with no forwarding.
REQ-026 A write to a non-busy register SHALL still be granted and performed; the busy bit stays 0.
REQ-027 The round-robin pointer and scoreboard SHALL be the only state besides the output registers.

Reset
REQ-028 While reset_n=0 (asynchronously, including mid-operation): busy=4'b0000, rf_write_enable=0, rf_dest_reg=0, rf_write_data=0, last-winner pointer = mem (so alu wins the first tie).
REQ-029 During reset, alu_gnt and mem_gnt SHALL be 0 and issue_ready SHALL be 1; any grant in the cycle reset asserts is discarded.
REQ-030 The first grant SHALL be possible in the first cycle after reset_n rises.

Verification
REQ-031 Reset, then alu_req=1, dest=2, data=8'hA5 for one cycle -> alu_gnt=1 that cycle; next cycle rf_write_enable=1, rf_dest_reg=2, rf_write_data=8'hA5; the following cycle rf_write_enable=0.
REQ-032 RR_ENABLE=1, both reqs held high for 4 cycles with distinct dests -> grants alternate alu, mem, alu, mem; never both high.
REQ-033 RR_ENABLE=0, both reqs held high for 3 cycles -> mem_gnt=1 on all 3 cycles and alu_gnt=0 on all 3.
REQ-034 issue_valid, dest=1 -> busy[1] set; src1=1 gives src1_busy=1; a second issue to dest 1 gives issue_ready=0; mem write to dest 1 -> busy[1]=0 at the write edge and issue_ready=1.
REQ-035 Same cycle: issue to dest 3 while a grant writes dest 3 (busy) -> after the edge busy[3]=1; with a different dest the issued bit sets and the written bit clears.
REQ-036 Assert reset_n=0 mid-cycle after a grant, before the write edge -> rf_write_enable=0 immediately, busy=0, no write occurs after release.
